// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: decimated conversion requests, sample FIFO and a Wishbone
// register file with level interrupt.
module adc_capture_ctrl #(
    parameter int unsigned DW      = 12,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic          wb_clk_o,
    input  logic          rst_pad_i,
    input  logic          adc_clk,
    input  logic [1:0]    wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          conv_start_o,
    input  logic          conv_done_i,
    input  logic [DW-1:0] conv_data_i,
    output logic          irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StStore} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [DW-1:0]   sample_q, sample_d;
    logic            adc_q;
    logic [3:0]      decim_cnt_q;
    logic            en_q;
    logic [3:0]      decim_q;
    logic [4:0]      thresh_q;
    logic            ovf_q, tmo_q;
    logic [4:0]      count_q;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [DW-1:0]   mem_q [DEPTH];
    logic            ack_q;
    logic [31:0]     dat_q;
    logic            irq_q;

    logic            wb_req, wr_en, rd_en, adc_edge, trigger;
    logic            full, empty, push, pop, drop, tmo_set, busy;
    logic [31:0]     rd_data;
    logic            unused_dat;

    assign wb_req   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en    = wb_req & wb_we_i;
    assign rd_en    = wb_req & ~wb_we_i;
    assign adc_edge = adc_clk & ~adc_q;
    assign busy     = (state_q != StIdle);
    assign trigger  = adc_edge & en_q & ~busy & (decim_cnt_q == decim_q);
    assign full     = (count_q == 5'(DEPTH));
    assign empty    = (count_q == 5'd0);
    assign pop      = rd_en & (wb_adr_i == 2'd2) & ~empty;

    assign unused_dat = ^wb_dat_i[31:8];

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        sample_d = sample_q;
        push     = 1'b0;
        drop     = 1'b0;
        tmo_set  = 1'b0;
        case (state_q)
            StIdle: begin
                if (trigger) state_d = StStart;
            end
            StStart: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (conv_done_i) begin
                    sample_d = conv_data_i;
                    state_d  = StStore;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StStore: begin
                if (full) drop = 1'b1;
                else      push = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            2'd0: rd_data = {24'd0, decim_q, 3'd0, en_q};
            2'd1: rd_data = {19'd0, count_q, 5'd0, tmo_q, ovf_q, busy};
            2'd2: rd_data = empty ? 32'd0 : {{(32 - DW){1'b0}}, mem_q[rd_ptr_q]};
            2'd3: rd_data = {27'd0, thresh_q};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_o or posedge rst_pad_i) begin
        if (rst_pad_i) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sample_q <= sample_d;
        end
    end

    always_ff @(posedge wb_clk_o or posedge rst_pad_i) begin
        if (rst_pad_i) begin
            adc_q       <= 1'b0;
            decim_cnt_q <= '0;
            en_q        <= 1'b0;
            decim_q     <= '0;
            thresh_q    <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            adc_q <= adc_clk;
            ack_q <= wb_req;
            if (wb_req) dat_q <= rd_data;

            if (wr_en && wb_adr_i == 2'd0) begin
                en_q    <= wb_dat_i[0];
                decim_q <= wb_dat_i[7:4];
            end
            if (wr_en && wb_adr_i == 2'd3) thresh_q <= wb_dat_i[4:0];

            // Edges seen while a conversion is in flight do not advance the count.
            if (!en_q) begin
                decim_cnt_q <= '0;
            end else if (adc_edge && !busy) begin
                decim_cnt_q <= (decim_cnt_q == decim_q) ? 4'd0 : decim_cnt_q + 4'd1;
            end

            if (drop) ovf_q <= 1'b1;
            else if (wr_en && wb_adr_i == 2'd1 && wb_dat_i[1]) ovf_q <= 1'b0;
            if (tmo_set) tmo_q <= 1'b1;
            else if (wr_en && wb_adr_i == 2'd1 && wb_dat_i[2]) tmo_q <= 1'b0;

            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + 5'd1;
            else if (pop && !push) count_q <= count_q - 5'd1;

            irq_q <= ((thresh_q != 5'd0) && (count_q >= thresh_q)) || ovf_q || tmo_q;
        end
    end

    always_ff @(posedge wb_clk_o) begin
        if (push) mem_q[wr_ptr_q] <= sample_q;
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign conv_start_o = (state_q == StStart);
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl; captured samples are predicted into a queue and
// checked in order on DATA reads.
module tb_adc_capture_ctrl;

    localparam int unsigned DW      = 12;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 63;

    logic          wb_clk_o    = 1'b0;
    logic          rst_pad_i   = 1'b0;
    logic          adc_clk     = 1'b0;
    logic [1:0]    wb_adr_i    = '0;
    logic [31:0]   wb_dat_i    = '0;
    logic          wb_we_i     = 1'b0;
    logic          wb_stb_i    = 1'b0;
    logic          wb_cyc_i    = 1'b0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          conv_start_o;
    logic          conv_done_i = 1'b0;
    logic [DW-1:0] conv_data_i = '0;
    logic          irq_o;

    int            total = 0;
    int            bad = 0;
    int            start_cnt = 0;
    int            s0;
    logic          resp_en = 1'b0;
    int            resp_delay = 3;
    logic [DW-1:0] resp_data = '0;
    logic [DW-1:0] resp_step = '0;
    logic          model_ovf = 1'b0;
    logic [31:0]   exp_q [$];

    always #5 wb_clk_o = ~wb_clk_o;

    adc_capture_ctrl #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_o     (wb_clk_o),
        .rst_pad_i    (rst_pad_i),
        .adc_clk      (adc_clk),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_we_i      (wb_we_i),
        .wb_stb_i     (wb_stb_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .conv_start_o (conv_start_o),
        .conv_done_i  (conv_done_i),
        .conv_data_i  (conv_data_i),
        .irq_o        (irq_o)
    );

    always @(negedge wb_clk_o) begin
        if (conv_start_o === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_o);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        logic ok;
        ok   = 1'b0;
        rdat = '0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = wdat;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick(1);
            if (wb_ack_o === 1'b1) begin
                ok   = 1'b1;
                rdat = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        check("wb_ack_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wb_wr(input logic [1:0] adr, input logic [31:0] d);
        logic [31:0] rd;
        wb_xfer(1'b1, adr, d, rd);
    endtask

    task automatic wb_rd(input logic [1:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        wb_xfer(1'b0, adr, 32'd0, rd);
        check(tag, rd, exp);
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] exp;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else                  exp = 32'd0;
        wb_rd(2'd2, exp, tag);
    endtask

    // One adc_clk period of 16 cycles; answers each start pulse after resp_delay cycles
    // and predicts where the sample lands.
    task automatic adc_edge();
        int since;
        since   = -1;
        adc_clk = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 4) adc_clk = 1'b0;
            tick(1);
            conv_done_i = 1'b0;
            if (conv_start_o === 1'b1 && resp_en) since = 0;
            else if (since >= 0) since++;
            if (since == resp_delay) begin
                conv_done_i = 1'b1;
                conv_data_i = resp_data;
                if (exp_q.size() < DEPTH) exp_q.push_back({20'd0, resp_data});
                else                      model_ovf = 1'b1;
                resp_data = resp_data + resp_step;
                since = -1;
            end
        end
        conv_done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_pad_i = 1'b1;
        #1;
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_start", {31'd0, conv_start_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        tick(3);
        rst_pad_i = 1'b0;
        tick(1);
        wb_rd(2'd0, 32'd0, "rst_ctrl");
        wb_rd(2'd1, 32'd0, "rst_status");
        wb_rd(2'd3, 32'd0, "rst_thresh");
        rd_data("empty_data");
        wb_rd(2'd1, 32'd0, "empty_status");

        // Every edge converts, sample 0xABC
        resp_en = 1'b1; resp_delay = 3; resp_data = 12'hABC; resp_step = '0;
        wb_wr(2'd0, 32'h1);
        tick(1);
        check("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
        s0 = start_cnt;
        adc_edge();
        check("t1_starts1", 32'(start_cnt - s0), 32'd1);
        wb_rd(2'd1, 32'h100, "t1_status_cnt1");
        rd_data("t1_data0");
        wb_rd(2'd1, 32'h0, "t1_status_cnt0");
        s0 = start_cnt;
        adc_edge();
        adc_edge();
        check("t1_starts2", 32'(start_cnt - s0), 32'd2);
        rd_data("t1_data1");
        rd_data("t1_data2");

        // DECIM=3: one conversion per four edges
        resp_data = 12'h111; resp_step = 12'h111;
        wb_wr(2'd0, 32'h31);
        wb_rd(2'd0, 32'h31, "t2_ctrl_rb");
        s0 = start_cnt;
        repeat (8) adc_edge();
        check("t2_starts", 32'(start_cnt - s0), 32'd2);
        rd_data("t2_data0");
        rd_data("t2_data1");
        wb_rd(2'd1, 32'h0, "t2_status");

        // No conv_done: timeout after TIMEOUT wait cycles
        resp_en = 1'b0;
        wb_wr(2'd0, 32'h1);
        s0 = start_cnt;
        adc_clk = 1'b1;
        tick(65);
        check("t3_irq_before", {31'd0, irq_o}, 32'd0);
        tick(1);
        check("t3_irq_after", {31'd0, irq_o}, 32'd1);
        adc_clk = 1'b0;
        tick(4);
        check("t3_starts", 32'(start_cnt - s0), 32'd1);
        wb_rd(2'd1, 32'h4, "t3_status_tmo");
        wb_wr(2'd1, 32'h4);
        tick(2);
        check("t3_irq_clr", {31'd0, irq_o}, 32'd0);
        wb_rd(2'd1, 32'h0, "t3_status_clr");

        // DEPTH+1 conversions without reads: overflow
        resp_en = 1'b1; resp_data = 12'h100; resp_step = 12'h001; model_ovf = 1'b0;
        s0 = start_cnt;
        repeat (DEPTH + 1) adc_edge();
        check("t4_starts", 32'(start_cnt - s0), 32'(DEPTH + 1));
        wb_rd(2'd1, (32'(exp_q.size()) << 8) | (32'(model_ovf) << 1), "t4_status_full");
        check("t4_irq", {31'd0, irq_o}, 32'd1);
        for (int i = 0; i < DEPTH; i++) rd_data("t4_data");
        wb_rd(2'd1, 32'h2, "t4_status_drained");
        wb_wr(2'd1, 32'h2);
        model_ovf = 1'b0;
        wb_rd(2'd1, 32'h0, "t4_status_clr");

        // THRESH=2 interrupt
        resp_data = 12'h055; resp_step = 12'h001;
        wb_wr(2'd3, 32'h2);
        wb_rd(2'd3, 32'h2, "t5_thresh_rb");
        adc_edge();
        check("t5_irq_cnt1", {31'd0, irq_o}, 32'd0);
        adc_edge();
        check("t5_irq_cnt2", {31'd0, irq_o}, 32'd1);
        rd_data("t5_data0");
        tick(2);
        check("t5_irq_drop", {31'd0, irq_o}, 32'd0);
        rd_data("t5_data1");
        wb_wr(2'd3, 32'h0);

        // Reset while waiting for conv_done
        resp_en = 1'b0;
        wb_rd(2'd0, 32'h1, "t6_ctrl");
        adc_clk = 1'b1;
        tick(3);
        adc_clk = 1'b0;
        wb_rd(2'd1, 32'h1, "t6_busy");
        rst_pad_i = 1'b1;
        #1;
        check("t6_rst_dat", wb_dat_o, 32'd0);
        check("t6_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("t6_rst_start", {31'd0, conv_start_o}, 32'd0);
        check("t6_rst_irq", {31'd0, irq_o}, 32'd0);
        tick(2);
        rst_pad_i = 1'b0;
        tick(1);
        conv_done_i = 1'b1;
        conv_data_i = 12'h777;
        tick(1);
        conv_done_i = 1'b0;
        tick(5);
        wb_rd(2'd1, 32'h0, "t6_status");
        rd_data("t6_data_empty");
        wb_rd(2'd0, 32'h0, "t6_ctrl_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter DW, default 12: ADC sample width in bits (1..16).
REQ-002 SHALL have parameter DEPTH, default 8: sample FIFO depth, power of 2, 2..16.
REQ-003 SHALL have parameter TIMEOUT, default 63: max wb_clk_o cycles to wait for conv_done_i.
REQ-004 SHALL have port wb_clk_o  in  1  system clock; all logic rising-edge.
REQ-005 SHALL have port rst_pad_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port adc_clk  in  1  sample-rate clock, generated in the wb_clk_o domain; treated as a data level, no synchronizer.
REQ-007 SHALL have ports wb_adr_i in 2, wb_dat_i in 32, wb_we_i in 1, wb_stb_i in 1, wb_cyc_i in 1: Wishbone slave request.
REQ-008 SHALL have ports wb_dat_o out 32, wb_ack_o out 1: Wishbone slave response.
REQ-009 SHALL have port conv_start_o  out  1  one-cycle conversion request to ADC front end.
REQ-010 SHALL have ports conv_done_i in 1, conv_data_i in DW: conversion complete strobe; data valid in the same cycle.
REQ-011 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-012 SHALL decode registers: 0 CTRL (RW; bit0 EN, bits7:4 DECIM), 1 STATUS (bit0 BUSY, bit1 OVF, bit2 TMO, bits12:8 fill COUNT), 2 DATA (RO, pop), 3 THRESH (RW, bits4:0); unused bits read 0.
REQ-013 SHALL assert wb_ack_o for exactly one cycle, the cycle after wb_cyc_i&wb_stb_i is seen with wb_ack_o low; no ack in the cycle following an ack.
REQ-014 SHALL register wb_dat_o in the ack cycle; writes take effect in the ack cycle.
REQ-015 SHALL clear OVF/TMO by writing 1 to the bit at STATUS (W1C); other STATUS bits ignore writes.
REQ-016 SHALL detect adc_clk rising edge as adc_clk=1 and registered adc_clk=0.
REQ-017 SHALL hold a decimation counter: on each edge with EN=1, if counter==DECIM then trigger and reset counter to 0, else increment; DECIM=0 triggers every edge.
REQ-018 SHALL implement FSM IDLE -> START -> WAIT -> STORE -> IDLE.
REQ-019 SHALL leave IDLE to START only on a trigger; START drives conv_start_o=1 for exactly one cycle, i.e. the cycle after the edge.
REQ-020 SHALL in WAIT capture conv_data_i and go to STORE on conv_done_i; after TIMEOUT cycles without it, set TMO and return to IDLE without pushing.
REQ-021 SHALL in STORE push the captured sample (zero-extended to 32 bits on read) if FIFO not full; if full, drop sample and set OVF.
REQ-022 SHALL ignore adc_clk edges while not in IDLE; decimation counter does not advance on them.
REQ-023 SHALL report BUSY=1 whenever FSM is not IDLE.
REQ-024 SHALL pop one entry on a DATA read ack; DATA read when empty returns 0 and leaves pointers unchanged.
REQ-025 SHALL, on simultaneous push and pop, perform both; COUNT unchanged; a pop from a one-entry FIFO returns the old entry.
REQ-026 SHALL let in-flight conversion finish (or time out) when EN is cleared; no new START issued; decimation counter reset to 0.
REQ-027 SHALL drive irq_o = (THRESH!=0 and COUNT>=THRESH) or OVF or TMO, registered.
REQ-028 SHALL ignore conv_done_i outside WAIT.

Reset
REQ-029 SHALL on rst_pad_i, immediately and asynchronously: FSM IDLE, CTRL/THRESH/flags 0, FIFO empty, counters 0, wb_ack_o/wb_dat_o/conv_start_o/irq_o 0.
REQ-030 SHALL on reset mid-conversion discard the conversion; conv_done_i after reset release is ignored.

Verification
REQ-031 SHALL cover: EN=1, DECIM=0, conv_done_i 3 cycles after start with data 0xABC -> one start pulse per adc_clk edge, DATA read returns 0x00000ABC, COUNT back to 0.
REQ-032 SHALL cover: DECIM=3, 8 adc_clk edges -> exactly 2 conv_start_o pulses.
REQ-033 SHALL cover: conv_done_i never asserted -> TMO=1 after 63 WAIT cycles, irq_o=1, no push; W1C clears TMO and irq_o.
REQ-034 SHALL cover: DEPTH+1 conversions with no reads -> COUNT=8, OVF=1, first 8 samples read in order.
REQ-035 SHALL cover: THRESH=2 -> irq_o rises after second push, falls after a DATA read drops COUNT to 1.
REQ-036 SHALL cover: rst_pad_i asserted in WAIT -> outputs 0 same cycle, late conv_done_i produces no push.
